// File: rtl/sb_tx_arbiter.sv
// Sideband TX arbiter: frame-atomic sharing of the SB serializer between the
// LT source (index 0) and the AT command/response generators.
module sb_tx_arbiter #(
  parameter int NUM_REQ       = 3,
  parameter int DATA_W        = 8,
  parameter int GAP_CYCLES    = 2,
  parameter int STALL_TIMEOUT = 64,
  parameter int LT_PRIORITY   = 1
) (
  input  logic                       sb_clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         in_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  in_data,
  input  logic [NUM_REQ-1:0]         in_last,
  output logic [NUM_REQ-1:0]         in_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic [$clog2(NUM_REQ)-1:0] out_src,
  output logic                       out_abort,
  output logic                       busy,
  output logic [7:0]                 abort_cnt
);

  // state | meaning
  // IDLE  | no frame owned; pending requests are arbitrated this cycle
  // XFER  | granted source passes bytes straight through to the serializer
  // GAP   | enforced idle gap after a frame completes or is aborted
  typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

  localparam int SRC_W   = $clog2(NUM_REQ);
  localparam int STALL_W = $clog2(STALL_TIMEOUT);
  localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [SRC_W-1:0]   RR_BASE    = SRC_W'((LT_PRIORITY != 0) ? 1 : 0);
  localparam logic [STALL_W-1:0] STALL_LOAD = STALL_W'(STALL_TIMEOUT - 1);
  localparam logic [GAP_W-1:0]   GAP_LOAD   = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t             state_q, state_d;
  logic [SRC_W-1:0]   gnt_q;
  logic [SRC_W-1:0]   rr_q, rr_next;
  logic [STALL_W-1:0] stall_q;
  logic [GAP_W-1:0]   gap_q;
  logic [7:0]         abort_cnt_q;

  logic [SRC_W-1:0]   win;
  logic               win_found;
  logic [SRC_W:0]     scan_sum;
  logic [SRC_W-1:0]   scan_idx;
  logic               done;

  logic [DATA_W-1:0]  src_data [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign src_data[i] = in_data[i*DATA_W +: DATA_W];
  end

  // LT pre-empts the scan; otherwise first requester at or after rr_q, wrapping
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    scan_sum  = '0;
    scan_idx  = '0;
    if (LT_PRIORITY != 0 && in_valid[0]) begin
      win_found = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_sum = {1'b0, rr_q} + (SRC_W+1)'(k);
        if (scan_sum >= (SRC_W+1)'(NUM_REQ)) scan_sum = scan_sum - (SRC_W+1)'(NUM_REQ);
        scan_idx = scan_sum[SRC_W-1:0];
        if (!win_found && in_valid[scan_idx] && !(LT_PRIORITY != 0 && scan_idx == '0)) begin
          win       = scan_idx;
          win_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rr_next = rr_q;
    if (!(LT_PRIORITY != 0 && gnt_q == '0)) begin
      if (int'(gnt_q) == NUM_REQ - 1) rr_next = RR_BASE;
      else                            rr_next = gnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    in_ready  = '0;
    out_abort = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: if (win_found) state_d = XFER;
      XFER: begin
        out_valid       = in_valid[gnt_q];
        out_data        = src_data[gnt_q];
        out_last        = in_last[gnt_q];
        in_ready[gnt_q] = out_ready;
        out_abort       = !in_valid[gnt_q] && (stall_q == '0);
        done            = (out_valid && out_ready && out_last) || out_abort;
        if (done) state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
      end
      GAP: if (gap_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // stall_q is a down-counter reloaded whenever the source presents a byte
  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      rr_q        <= RR_BASE;
      stall_q     <= '0;
      gap_q       <= '0;
      abort_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (win_found) begin
            gnt_q   <= win;
            stall_q <= STALL_LOAD;
          end
        end
        XFER: begin
          if (in_valid[gnt_q])    stall_q <= STALL_LOAD;
          else if (stall_q != '0) stall_q <= stall_q - 1'b1;
          if (done) begin
            rr_q  <= rr_next;
            gap_q <= GAP_LOAD;
          end
          if (out_abort && abort_cnt_q != 8'hFF) abort_cnt_q <= abort_cnt_q + 1'b1;
        end
        GAP: if (gap_q != '0) gap_q <= gap_q - 1'b1;
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign out_src   = gnt_q;
  assign abort_cnt = abort_cnt_q;

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// Bench for sb_tx_arbiter: behavioural model checked every cycle, directed
// scenarios with literal expectations, randomized frames, and a zero-gap instance.
module tb_sb_tx_arbiter;

  localparam int NR  = 3;
  localparam int DW  = 8;
  localparam int GAP = 2;
  localparam int STO = 64;
  localparam int LTP = 1;

  logic          sb_clk = 1'b0;
  logic          rst    = 1'b0;
  logic [NR-1:0] in_valid, in_last, in_ready;
  logic [NR*DW-1:0] in_data;
  logic          out_valid, out_last, out_ready, out_abort, busy;
  logic [DW-1:0] out_data;
  logic [1:0]    out_src;
  logic [7:0]    abort_cnt;

  logic [NR-1:0] g_in_valid, g_in_last, g_in_ready;
  logic [NR*DW-1:0] g_in_data;
  logic          g_out_valid, g_out_last, g_out_ready, g_out_abort, g_busy;
  logic [DW-1:0] g_out_data;
  logic [1:0]    g_out_src;
  logic [7:0]    g_abort_cnt;

  always #5 sb_clk = ~sb_clk;

  sb_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .GAP_CYCLES(GAP), .STALL_TIMEOUT(STO),
                  .LT_PRIORITY(LTP)) dut (
    .sb_clk(sb_clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .out_src(out_src), .out_abort(out_abort), .busy(busy),
    .abort_cnt(abort_cnt));

  sb_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .GAP_CYCLES(0), .STALL_TIMEOUT(STO),
                  .LT_PRIORITY(LTP)) dut_g0 (
    .sb_clk(sb_clk), .rst(rst), .in_valid(g_in_valid), .in_data(g_in_data), .in_last(g_in_last),
    .in_ready(g_in_ready), .out_valid(g_out_valid), .out_data(g_out_data), .out_last(g_out_last),
    .out_ready(g_out_ready), .out_src(g_out_src), .out_abort(g_out_abort), .busy(g_busy),
    .abort_cnt(g_abort_cnt));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 owning a frame, 2 gap
  int m_phase, m_gnt, m_rr, m_gap_left, m_stall, m_aborts;
  int glog[$];
  logic [10:0] blog[$];
  logic busy_q = 1'b0;

  function automatic int pick(input logic [NR-1:0] v, input int rr);
    if (LTP != 0 && v[0]) return 0;
    for (int k = 0; k < NR; k++) begin
      int idx;
      idx = (rr + k) % NR;
      if (!(LTP != 0 && idx == 0) && v[idx]) return idx;
    end
    return -1;
  endfunction

  always @(negedge sb_clk) begin
    logic [NR-1:0] e_rdy;
    logic e_ov, e_last, e_abort;
    logic [DW-1:0] e_data;
    int w;
    if (!rst) begin
      m_phase = 0; m_gnt = 0; m_rr = (LTP != 0) ? 1 : 0;
      m_gap_left = 0; m_stall = 0; m_aborts = 0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_src", out_src, 0);
      chk("rst_abort_cnt", abort_cnt, 0);
      chk("rst_out_abort", out_abort, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
    end else begin
      e_ov = 0; e_last = 0; e_abort = 0; e_data = '0; e_rdy = '0;
      if (m_phase == 1) begin
        for (int i = 0; i < NR; i++) begin
          if (i == m_gnt) begin
            e_ov    = in_valid[i];
            e_last  = in_last[i];
            e_data  = in_data[i*DW +: DW];
            e_rdy[i] = out_ready;
            e_abort = !in_valid[i] && (m_stall + 1 == STO);
          end
        end
      end
      chk("m_busy", busy, (m_phase != 0) ? 1 : 0);
      chk("m_out_valid", out_valid, e_ov);
      chk("m_in_ready", in_ready, e_rdy);
      chk("m_out_abort", out_abort, e_abort);
      chk("m_out_src", out_src, m_gnt);
      chk("m_abort_cnt", abort_cnt, m_aborts);
      if (m_phase == 1) begin
        chk("m_out_data", out_data, e_data);
        chk("m_out_last", out_last, e_last);
      end
      if (busy && !busy_q) glog.push_back(int'(out_src));
      if (out_valid && out_ready) blog.push_back({out_src, out_last, out_data});
      case (m_phase)
        0: begin
          w = pick(in_valid, m_rr);
          if (w >= 0) begin m_gnt = w; m_phase = 1; m_stall = 0; end
        end
        1: begin
          if ((e_ov && out_ready && e_last) || e_abort) begin
            if (e_abort && m_aborts < 255) m_aborts++;
            if (!(LTP != 0 && m_gnt == 0))
              m_rr = (m_gnt + 1 == NR) ? ((LTP != 0) ? 1 : 0) : m_gnt + 1;
            if (GAP > 0) begin m_phase = 2; m_gap_left = GAP; end
            else m_phase = 0;
          end else begin
            m_stall = e_ov ? 0 : m_stall + 1;
          end
        end
        default: begin
          m_gap_left--;
          if (m_gap_left == 0) m_phase = 0;
        end
      endcase
    end
    busy_q = busy;
  end

  // Source frame generators
  int f_len[NR], f_pos[NR], f_sat[NR], f_slen[NR], f_pend[NR];
  logic [7:0] f_base[NR];
  bit f_act[NR];
  bit rnd_ready = 0, rnd_gen = 0;
  logic s_ov, s_last, s_busy, s_abort;
  logic [DW-1:0] s_data;
  logic [1:0] s_src;
  logic [NR-1:0] s_iv;

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (f_act[i]) begin
        in_valid[i] = !(f_pos[i] == f_sat[i] && f_slen[i] > 0);
        in_data[i*DW +: DW] = 8'(f_base[i] + 8'(f_pos[i]));
        in_last[i] = (f_pos[i] == f_len[i] - 1);
      end else begin
        in_valid[i] = 1'b0;
        in_data[i*DW +: DW] = '0;
        in_last[i] = 1'b0;
      end
    end
  endtask

  task automatic start_frame(input int i, input int len, input logic [7:0] base,
                             input int sat, input int slen, input int pend);
    f_act[i] = 1; f_pos[i] = 0; f_len[i] = len; f_base[i] = base;
    f_sat[i] = sat; f_slen[i] = slen; f_pend[i] = pend;
    drive();
  endtask

  task automatic rand_frame(input int i);
    int len, r;
    len = $urandom_range(1, 6);
    r = $urandom_range(0, 49);
    start_frame(i, len, 8'($urandom), (len > 1) ? $urandom_range(1, len - 1) : 99,
                (r == 0) ? 70 : ((r < 6) ? $urandom_range(1, 4) : 0), 0);
  endtask

  task automatic step();
    logic [NR-1:0] acc;
    @(negedge sb_clk);
    acc = in_valid & in_ready;
    s_ov = out_valid; s_data = out_data; s_last = out_last; s_busy = busy;
    s_src = out_src; s_abort = out_abort; s_iv = in_valid;
    @(posedge sb_clk); #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 9) < 7);
    for (int i = 0; i < NR; i++) begin
      if (f_act[i]) begin
        if (acc[i]) begin
          f_pos[i]++;
          if (f_pos[i] == f_len[i]) begin
            f_act[i] = 0;
            if (f_pend[i] > 0) begin
              f_pend[i]--; f_base[i] = f_base[i] + 8'h10;
              f_pos[i] = 0; f_sat[i] = 99; f_act[i] = 1;
            end
          end
        end else if (s_abort && int'(s_src) == i) begin
          f_pos[i] = 0; f_slen[i] = 0;
        end else if (f_pos[i] == f_sat[i] && f_slen[i] > 0) begin
          f_slen[i]--;
        end
      end
    end
    if (rnd_gen)
      for (int i = 0; i < NR; i++)
        if (!f_act[i] && $urandom_range(0, 5) == 0) rand_frame(i);
    drive();
  endtask

  function automatic bit any_act();
    bit a = 0;
    for (int i = 0; i < NR; i++) a |= f_act[i];
    return a;
  endfunction

  task automatic wait_done(input int budget, input string nm);
    int n = 0;
    while ((any_act() || busy) && n < budget) begin step(); n++; end
    chk(nm, {31'd0, any_act() || busy}, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt, stalled;
    bit seen, prev, b2b, hs;
    logic [7:0] gdat;

    out_ready = 0; in_valid = '0; in_last = '0; in_data = '0;
    g_in_valid = '0; g_in_last = '0; g_in_data = '0; g_out_ready = 0;
    for (int i = 0; i < NR; i++) f_act[i] = 0;
    repeat (3) @(posedge sb_clk);
    #2;
    chk("init_out_valid", out_valid, 0);
    chk("init_busy", busy, 0);
    chk("init_abort_cnt", abort_cnt, 0);
    #1 rst = 1;
    out_ready = 1;

    // three simultaneous requests: LT first, then round-robin from 1
    glog.delete();
    start_frame(0, 2, 8'h00, 99, 0, 0);
    start_frame(1, 2, 8'h10, 99, 0, 0);
    start_frame(2, 2, 8'h20, 99, 0, 0);
    wait_done(100, "b_timeout");
    chk("b_grants", glog.size(), 3);
    chk("b_g0", glog[0], 0);
    chk("b_g1", glog[1], 1);
    chk("b_g2", glog[2], 2);

    // src 1 and 2 only: alternation never lands on index 0
    glog.delete();
    start_frame(1, 2, 8'h30, 99, 0, 1);
    start_frame(2, 2, 8'h40, 99, 0, 1);
    wait_done(200, "c_timeout");
    chk("c_grants", glog.size(), 4);
    chk("c_g0", glog[0], 1);
    chk("c_g1", glog[1], 2);
    chk("c_g2", glog[2], 1);
    chk("c_g3", glog[3], 2);

    // single 4-byte frame from src 1
    start_frame(1, 4, 8'hA1, 99, 0, 0);
    step();
    chk("a_req_cycle_valid", s_ov, 0);
    chk("a_req_cycle_busy", s_busy, 0);
    step();
    chk("a_b0_valid", s_ov, 1);
    chk("a_b0_data", s_data, 8'hA1);
    chk("a_src", s_src, 1);
    step(); chk("a_b1_data", s_data, 8'hA2);
    step(); chk("a_b2_data", s_data, 8'hA3); chk("a_b2_last", s_last, 0);
    step(); chk("a_b3_data", s_data, 8'hA4); chk("a_b3_last", s_last, 1);
    cnt = 0;
    repeat (4) begin step(); if (s_busy) cnt++; chk("a_gap_valid", s_ov, 0); end
    chk("a_gap_cycles", cnt, 2);

    // LT arrives mid-frame of src 2: no preemption
    glog.delete(); blog.delete();
    start_frame(2, 5, 8'hC0, 99, 0, 0);
    n = 0;
    while (blog.size() < 2 && n < 50) begin step(); n++; end
    start_frame(0, 2, 8'h50, 99, 0, 0);
    wait_done(200, "d_timeout");
    chk("d_grants", glog.size(), 2);
    chk("d_g0", glog[0], 2);
    chk("d_g1", glog[1], 0);
    chk("d_bytes", blog.size(), 7);
    chk("d_last_src2", blog[4], {2'd2, 1'b1, 8'hC4});
    chk("d_first_src0", blog[5], {2'd0, 1'b0, 8'h50});

    // src 1 stalls 64 cycles after byte 2 while src 2 waits
    glog.delete();
    start_frame(1, 4, 8'h30, 2, 64, 0);
    start_frame(2, 2, 8'h60, 99, 0, 0);
    stalled = 0; n = 0;
    do begin
      step(); n++;
      if (s_busy && s_src == 2'd1 && !s_iv[1]) stalled++;
    end while (!s_abort && n < 300);
    chk("e_abort_seen", s_abort, 1);
    chk("e_stalled_cycles", stalled, 64);
    chk("e_abort_src", s_src, 1);
    chk("e_abort_cnt", abort_cnt, 1);
    wait_done(300, "e_timeout");
    chk("e_grants", glog.size(), 3);
    chk("e_g1", glog[1], 2);
    chk("e_g2", glog[2], 1);

    // serializer backpressure is not a stall
    start_frame(1, 3, 8'h80, 99, 0, 0);
    out_ready = 0;
    step();
    seen = 0;
    repeat (100) begin step(); if (s_abort) seen = 1; end
    chk("f_no_abort", seen, 0);
    chk("f_still_busy", s_busy, 1);
    chk("f_abort_cnt", abort_cnt, 1);
    out_ready = 1;
    wait_done(100, "f_timeout");

    // reset mid-frame; round-robin pointer must return to 1
    blog.delete();
    start_frame(1, 4, 8'h90, 99, 0, 0);
    n = 0;
    while (blog.size() < 1 && n < 20) begin step(); n++; end
    #2 rst = 0;
    #1;
    chk("g_rst_out_valid", out_valid, 0);
    chk("g_rst_busy", busy, 0);
    chk("g_rst_in_ready", in_ready, 0);
    chk("g_rst_out_src", out_src, 0);
    chk("g_rst_abort_cnt", abort_cnt, 0);
    for (int i = 0; i < NR; i++) f_act[i] = 0;
    drive();
    step(); step();
    #2 rst = 1;
    glog.delete();
    start_frame(1, 1, 8'hB1, 99, 0, 0);
    start_frame(2, 1, 8'hB2, 99, 0, 0);
    wait_done(100, "g_timeout");
    chk("g_grants", glog.size(), 2);
    chk("g_g0", glog[0], 1);
    chk("g_g1", glog[1], 2);

    // randomized traffic
    rnd_gen = 1; rnd_ready = 1;
    repeat (3000) step();
    rnd_gen = 0; rnd_ready = 0; out_ready = 1;
    wait_done(3000, "h_timeout");

    // zero-gap instance: back-to-back single-byte frames
    g_out_ready = 1; gdat = 8'h10;
    g_in_valid = 3'b010; g_in_last = 3'b010; g_in_data = {8'h00, gdat, 8'h00};
    cnt = 0; prev = 0; b2b = 0;
    repeat (12) begin
      @(negedge sb_clk);
      if (g_out_valid) begin
        cnt++;
        if (prev) b2b = 1;
        chk("g0_data", g_out_data, gdat);
      end
      hs = g_out_valid && g_out_ready;
      prev = g_out_valid;
      @(posedge sb_clk); #1;
      if (hs) begin gdat = gdat + 8'd1; g_in_data = {8'h00, gdat, 8'h00}; end
    end
    g_in_valid = '0;
    chk("g0_xfers", cnt, 6);
    chk("g0_back_to_back", b2b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
